// File: rtl/reg_bus_pkg.sv
// Shared types and idle bus values for reg_bus_master.
package reg_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_e;

    localparam logic BUS_EN_IDLE       = 1'b0;
    localparam logic BUS_STATE_IDLE    = 1'b0;
    localparam logic BUS_DOUT_IDLE_BIT = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reg_bus_master.sv
// Register-bus master: one store/fetch per command, setup/strobe/hold timed bus cycle.
// Latency: acceptance to rsp_valid = 1+SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES cycles.
// Backpressure: cmd_ready only in IDLE, no queueing; REG_BUS_MASTER_CNT_EN adds completion counters.
module reg_bus_master #(
    parameter int DATA_WIDTH    = 16,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_store,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
`ifdef REG_BUS_MASTER_CNT_EN
    output logic [15:0]           store_cnt,
    output logic [15:0]           fetch_cnt,
`endif
    output logic                  bus_en,
    output logic                  bus_state,
    output logic [DATA_WIDTH-1:0] bus_dout,
    input  logic [DATA_WIDTH-1:0] bus_din
);
    import reg_bus_pkg::*;

    localparam int CNT_W = $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  store_q, store_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  last_cyc;

    assign last_cyc = (cnt_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            store_q    <= 1'b0;
            data_q     <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            store_q    <= store_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Counter is reloaded with (phase length - 1) on entry and counts down to zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        store_d    = store_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                    store_d = cmd_store;
                    data_d  = cmd_store ? cmd_data : '0;
                end
            end
            ST_SETUP: begin
                if (last_cyc) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (last_cyc) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    if (!store_q) rsp_data_d = bus_din;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (last_cyc) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_DONE);
        bus_en    = BUS_EN_IDLE;
        bus_state = BUS_STATE_IDLE;
        bus_dout  = {DATA_WIDTH{BUS_DOUT_IDLE_BIT}};
        if (state_q == ST_SETUP || state_q == ST_STROBE || state_q == ST_HOLD) begin
            bus_state = store_q;
            bus_dout  = data_q;
        end
        if (state_q == ST_STROBE) bus_en = 1'b1;
    end

    assign rsp_data = rsp_data_q;

`ifdef REG_BUS_MASTER_CNT_EN
    logic [15:0] store_cnt_q, fetch_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            store_cnt_q <= '0;
            fetch_cnt_q <= '0;
        end else if (state_q == ST_DONE) begin
            if (store_q) store_cnt_q <= store_cnt_q + 16'd1;
            else         fetch_cnt_q <= fetch_cnt_q + 16'd1;
        end
    end

    assign store_cnt = store_cnt_q;
    assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench: default-timing master plus a 3/4/2 timing master, each with a simple slave register.
module tb_reg_bus_master;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // default-timing instance
    logic        cv, cs, cr, rv, be, bst;
    logic [15:0] cd, rd, bdo, bdi;
    logic [15:0] slave_q, slave_val;
    logic        slave_ld;

    // 3/4/2-timing instance
    logic        cv2, cs2, cr2, rv2, be2, bst2;
    logic [15:0] cd2, rd2, bdo2, bdi2;
    logic [15:0] slave2_q;

`ifdef REG_BUS_MASTER_CNT_EN
    logic [15:0] sc1, fc1, sc2, fc2;
`endif

    always @(posedge clk) begin
        if (slave_ld)       slave_q <= slave_val;
        else if (be && bst) slave_q <= bdo;
    end
    assign bdi = slave_q;

    always @(posedge clk) if (be2 && bst2) slave2_q <= bdo2;
    assign bdi2 = slave2_q;

    reg_bus_master u_dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cv), .cmd_ready(cr), .cmd_store(cs), .cmd_data(cd),
        .rsp_valid(rv), .rsp_data(rd),
`ifdef REG_BUS_MASTER_CNT_EN
        .store_cnt(sc1), .fetch_cnt(fc1),
`endif
        .bus_en(be), .bus_state(bst), .bus_dout(bdo), .bus_din(bdi)
    );

    reg_bus_master #(.DATA_WIDTH(16), .SETUP_CYCLES(3), .STROBE_CYCLES(4), .HOLD_CYCLES(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cv2), .cmd_ready(cr2), .cmd_store(cs2), .cmd_data(cd2),
        .rsp_valid(rv2), .rsp_data(rd2),
`ifdef REG_BUS_MASTER_CNT_EN
        .store_cnt(sc2), .fetch_cnt(fc2),
`endif
        .bus_en(be2), .bus_state(bst2), .bus_dout(bdo2), .bus_din(bdi2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at the negedge of cycle t; returns at the negedge of t+6 (IDLE again).
    task automatic cmd1(input string p, input logic st, input logic [15:0] d, input logic [15:0] exp_rd);
        cv = 1'b1; cs = st; cd = d;
        check({p, "_rdy_t"}, 32'(cr), 32'd1);
        @(negedge clk);
        cv = 1'b0; cs = ~st; cd = ~d;
        check({p, "_setup_state"}, 32'(bst), 32'(st));
        check({p, "_setup_dout"}, 32'(bdo), st ? 32'(d) : 32'd0);
        check({p, "_setup_en"}, 32'(be), 32'd0);
        check({p, "_busy_rdy"}, 32'(cr), 32'd0);
        @(negedge clk);
        check({p, "_strobe1_en"}, 32'(be), 32'd1);
        @(negedge clk);
        check({p, "_strobe2_en"}, 32'(be), 32'd1);
        check({p, "_strobe2_state"}, 32'(bst), 32'(st));
        @(negedge clk);
        check({p, "_hold_en"}, 32'(be), 32'd0);
        check({p, "_hold_dout"}, 32'(bdo), st ? 32'(d) : 32'd0);
        check({p, "_hold_rv"}, 32'(rv), 32'd0);
        @(negedge clk);
        check({p, "_done_rv"}, 32'(rv), 32'd1);
        check({p, "_done_rd"}, 32'(rd), 32'(exp_rd));
        @(negedge clk);
        check({p, "_after_rv"}, 32'(rv), 32'd0);
        check({p, "_after_rdy"}, 32'(cr), 32'd1);
    endtask

    // Long-timing instance: expects 10-cycle latency and a 4-cycle strobe.
    task automatic cmd2(input string p, input logic st, input logic [15:0] d, input logic [15:0] exp_rd);
        int k;
        int wid;
        cv2 = 1'b1; cs2 = st; cd2 = d;
        @(negedge clk);
        cv2 = 1'b0;
        k = 1;
        wid = 0;
        while (!rv2 && k < 30) begin
            if (be2) wid++;
            @(negedge clk);
            k++;
        end
        check({p, "_latency"}, 32'(k), 32'd10);
        check({p, "_en_width"}, 32'(wid), 32'd4);
        check({p, "_rd"}, 32'(rd2), 32'(exp_rd));
        @(negedge clk);
    endtask

    initial begin
        int nrv;
        int k;
        cv = 0; cs = 0; cd = '0; cv2 = 0; cs2 = 0; cd2 = '0;
        slave_ld = 0; slave_val = '0;
        repeat (3) @(negedge clk);
        check("rst_rdy", 32'(cr), 32'd1);
        check("rst_en", 32'(be), 32'd0);
        check("rst_state", 32'(bst), 32'd0);
        check("rst_dout", 32'(bdo), 32'd0);
        check("rst_rv", 32'(rv), 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst2_rdy", 32'(cr2), 32'd1);
`ifdef REG_BUS_MASTER_CNT_EN
        check("rst_scnt", 32'(sc1), 32'd0);
        check("rst_fcnt", 32'(fc1), 32'd0);
`endif
        reset_n = 1'b1;
        slave_ld = 1'b1; slave_val = 16'h0000;
        @(negedge clk);
        slave_ld = 1'b0;

        // store 0xA5A5; a store must not touch rsp_data
        cmd1("st", 1'b1, 16'hA5A5, 16'h0000);
        check("st_slave", 32'(slave_q), 32'h0000A5A5);

        // fetch from slave holding 0x1234
        slave_ld = 1'b1; slave_val = 16'h1234;
        @(negedge clk);
        slave_ld = 1'b0;
        cmd1("fe", 1'b0, 16'hFFFF, 16'h1234);
        slave_ld = 1'b1; slave_val = 16'hBEEF;
        @(negedge clk);
        slave_ld = 1'b0;
        @(negedge clk);
        check("fe_rd_held", 32'(rd), 32'h00001234);

        // back-to-back store 0x00FF then fetch with cmd_valid held
        cv = 1'b1; cs = 1'b1; cd = 16'h00FF;
        @(negedge clk);
        cs = 1'b0; cd = 16'h0000;
        check("b2b_state_kept", 32'(bst), 32'd1);
        check("b2b_dout_kept", 32'(bdo), 32'h000000FF);
        k = 1;
        while (!rv && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("b2b_lat1", 32'(k), 32'd5);
        check("b2b_rdy_at_rv", 32'(cr), 32'd0);
        @(negedge clk);
        check("b2b_rdy_after", 32'(cr), 32'd1);
        @(negedge clk);
        cv = 1'b0;
        check("b2b_2nd_accepted", 32'(cr), 32'd0);
        check("b2b_2nd_state", 32'(bst), 32'd0);
        check("b2b_2nd_dout", 32'(bdo), 32'd0);
        repeat (4) @(negedge clk);
        check("b2b_2nd_rv", 32'(rv), 32'd1);
        check("b2b_2nd_rd", 32'(rd), 32'h000000FF);
        @(negedge clk);

        // cmd_valid pulsed during STROBE is dropped
        cv = 1'b1; cs = 1'b1; cd = 16'h1111;
        @(negedge clk);
        cv = 1'b0;
        nrv = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin cv = 1'b1; cs = 1'b1; cd = 16'h2222; end
            if (i == 1) cv = 1'b0;
            if (rv) nrv++;
        end
        check("pulse_one_rsp", 32'(nrv), 32'd1);
        check("pulse_slave", 32'(slave_q), 32'h00001111);

        // reset asserted during STROBE aborts the transfer
        cv = 1'b1; cs = 1'b1; cd = 16'h3333;
        @(negedge clk);
        cv = 1'b0;
        @(negedge clk);
        check("abort_pre_en", 32'(be), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("abort_en_low", 32'(be), 32'd0);
        check("abort_rd_clr", 32'(rd), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        nrv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rv) nrv++;
        end
        check("abort_no_rsp", 32'(nrv), 32'd0);
        check("abort_rdy", 32'(cr), 32'd1);
        check("abort_slave", 32'(slave_q), 32'h00001111);
`ifdef REG_BUS_MASTER_CNT_EN
        check("abort_scnt", 32'(sc1), 32'd0);
`endif

        // long timing: 3/4/2
        cmd2("lt_st", 1'b1, 16'h0F0F, 16'h0000);
`ifdef REG_BUS_MASTER_CNT_EN
        check("lt_scnt1", 32'(sc2), 32'd1);
        check("lt_fcnt0", 32'(fc2), 32'd0);
`endif
        cmd2("lt_fe", 1'b0, 16'h0000, 16'h0F0F);
`ifdef REG_BUS_MASTER_CNT_EN
        check("lt_scnt1b", 32'(sc2), 32'd1);
        check("lt_fcnt1", 32'(fc2), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got=running expected=finished");
        $fatal(1);
    end

endmodule
